// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction memory.
// The fault threshold lives here so the loader and the memory cannot drift apart.
package inst_mem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } load_state_t;

    localparam logic [63:0] IMEM_FAULT_ADDR = 64'd1000;

endpackage

// File: rtl/inst_mem_loader.sv
// Boot/refill engine: streams 32-bit words from a valid/ready source into the
// L1 instruction memory write port, stalling the core until the image is complete.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR  = 64'd0,
    parameter logic [63:0] ADDR_LIMIT = IMEM_FAULT_ADDR,
    parameter int          CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [CNT_W-1:0] word_count,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [63:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             mem_we,
    output logic             mem_pcwrite,
    output logic             core_stall,
    output logic             busy,
    output logic             done,
    output logic             load_err,
    output logic [CNT_W-1:0] words_loaded
);

    load_state_t      state;
    load_state_t      state_next;
    logic [63:0]      addr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] target_q;
    logic             xfer;
    logic             start_ok;
    logic             in_limit;
    logic             last_word;

    assign xfer      = s_valid && s_ready;
    assign start_ok  = start && (state != LOAD);
    // Limit is checked on the address the word would be written to, before incrementing.
    assign in_limit  = addr_q < ADDR_LIMIT;
    assign last_word = (count_q + CNT_W'(1)) == target_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD: begin
                if (xfer) begin
                    if (!in_limit) begin
                        state_next = ERR;
                    end else if (last_word) begin
                        state_next = DONE;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_next = (word_count == '0) ? DONE : LOAD;
                end
            end
        endcase
    end

    always_comb begin
        s_ready    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        load_err   = 1'b0;
        core_stall = 1'b1;
        case (state)
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            DONE: begin
                done       = 1'b1;
                core_stall = 1'b0;
            end
            ERR: begin
                load_err = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Write port is registered: each accepted in-range word produces a one-cycle
    // write pulse on the following cycle, while address/data hold between pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q      <= BASE_ADDR;
            count_q     <= '0;
            target_q    <= '0;
            mem_we      <= 1'b0;
            mem_pcwrite <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            mem_we      <= 1'b0;
            mem_pcwrite <= 1'b0;
            if (start_ok) begin
                target_q <= word_count;
                addr_q   <= BASE_ADDR;
                count_q  <= '0;
            end else if (xfer && in_limit) begin
                mem_we      <= 1'b1;
                mem_pcwrite <= 1'b1;
                mem_addr    <= addr_q;
                mem_wdata   <= s_data;
                addr_q      <= addr_q + 64'd4;
                count_q     <= count_q + CNT_W'(1);
            end
        end
    end

    assign words_loaded = count_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench: two loaders (base 0 and base 992) share one randomized
// stimulus stream and are compared every cycle against a behavioural model.
module tb_inst_mem_loader;

    localparam logic [63:0] LIMIT   = 64'd1000;
    localparam int          P_IDLE  = 0;
    localparam int          P_LOAD  = 1;
    localparam int          P_DONE  = 2;
    localparam int          P_ERR   = 3;
    localparam int          BUDGET  = 300;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [7:0]  word_count;
    logic [31:0] s_data;
    logic        s_valid;

    logic        s_ready_o     [2];
    logic [63:0] mem_addr_o    [2];
    logic [31:0] mem_wdata_o   [2];
    logic        mem_we_o      [2];
    logic        mem_pcwrite_o [2];
    logic        core_stall_o  [2];
    logic        busy_o        [2];
    logic        done_o        [2];
    logic        load_err_o    [2];
    logic [7:0]  words_loaded_o[2];

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // model state, one slot per instance
    int          m_phase [2];
    logic [63:0] m_addr  [2];
    logic [63:0] m_waddr [2];
    logic [31:0] m_wdata [2];
    int          m_cnt   [2];
    int          m_target[2];
    bit          m_we    [2];

    logic [63:0] wa0[$];
    logic [31:0] wd0[$];
    logic [63:0] wa1[$];
    logic [31:0] wd1[$];
    int          lb0;
    int          lb1;
    logic [31:0] words[$];

    always #5 clk = ~clk;

    inst_mem_loader #(.BASE_ADDR(64'd0), .ADDR_LIMIT(64'd1000), .CNT_W(8)) dut0 (
        .clk(clk), .rstn(rstn), .start(start), .word_count(word_count),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_o[0]),
        .mem_addr(mem_addr_o[0]), .mem_wdata(mem_wdata_o[0]), .mem_we(mem_we_o[0]),
        .mem_pcwrite(mem_pcwrite_o[0]), .core_stall(core_stall_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .load_err(load_err_o[0]), .words_loaded(words_loaded_o[0])
    );

    inst_mem_loader #(.BASE_ADDR(64'd992), .ADDR_LIMIT(64'd1000), .CNT_W(8)) dut1 (
        .clk(clk), .rstn(rstn), .start(start), .word_count(word_count),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_o[1]),
        .mem_addr(mem_addr_o[1]), .mem_wdata(mem_wdata_o[1]), .mem_we(mem_we_o[1]),
        .mem_pcwrite(mem_pcwrite_o[1]), .core_stall(core_stall_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .load_err(load_err_o[1]), .words_loaded(words_loaded_o[1])
    );

    function automatic logic [63:0] base_of(input int inst);
        return (inst == 0) ? 64'd0 : 64'd992;
    endfunction

    task automatic check_output(input string name, input int inst,
                                input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s[%0d] at %0t: got %0h, expected %0h", name, inst, $time, act, exp);
        end
    endtask

    // Behavioural model: an accepted word is written if in range, else the load faults.
    always @(posedge clk or negedge rstn) begin
        for (int i = 0; i < 2; i++) begin
            if (!rstn) begin
                m_phase[i]  = P_IDLE;
                m_addr[i]   = base_of(i);
                m_cnt[i]    = 0;
                m_target[i] = 0;
                m_we[i]     = 1'b0;
                m_waddr[i]  = 64'd0;
                m_wdata[i]  = 32'd0;
            end else begin
                m_we[i] = 1'b0;
                if (m_phase[i] == P_LOAD) begin
                    if (s_valid) begin
                        if (m_addr[i] < LIMIT) begin
                            m_we[i]    = 1'b1;
                            m_waddr[i] = m_addr[i];
                            m_wdata[i] = s_data;
                            m_addr[i]  = m_addr[i] + 64'd4;
                            m_cnt[i]   = m_cnt[i] + 1;
                            if (m_cnt[i] == m_target[i]) m_phase[i] = P_DONE;
                        end else begin
                            m_phase[i] = P_ERR;
                        end
                    end
                end else if (start) begin
                    m_cnt[i]    = 0;
                    m_addr[i]   = base_of(i);
                    m_target[i] = int'(word_count);
                    m_phase[i]  = (word_count == 8'd0) ? P_DONE : P_LOAD;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                check_output("s_ready",      i, 64'(s_ready_o[i]),      64'(m_phase[i] == P_LOAD));
                check_output("busy",         i, 64'(busy_o[i]),         64'(m_phase[i] == P_LOAD));
                check_output("done",         i, 64'(done_o[i]),         64'(m_phase[i] == P_DONE));
                check_output("load_err",     i, 64'(load_err_o[i]),     64'(m_phase[i] == P_ERR));
                check_output("core_stall",   i, 64'(core_stall_o[i]),   64'(m_phase[i] != P_DONE));
                check_output("words_loaded", i, 64'(words_loaded_o[i]), 64'(m_cnt[i]));
                check_output("mem_we",       i, 64'(mem_we_o[i]),       64'(m_we[i]));
                check_output("mem_pcwrite",  i, 64'(mem_pcwrite_o[i]),  64'(m_we[i]));
                check_output("mem_addr",     i, mem_addr_o[i],          m_waddr[i]);
                check_output("mem_wdata",    i, 64'(mem_wdata_o[i]),    64'(m_wdata[i]));
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (mem_we_o[0]) begin
                wa0.push_back(mem_addr_o[0]);
                wd0.push_back(mem_wdata_o[0]);
            end
            if (mem_we_o[1]) begin
                wa1.push_back(mem_addr_o[1]);
                wd1.push_back(mem_wdata_o[1]);
            end
        end
    end

    // valid_pct: 100 = always valid, -1 = toggle 1,0,1,0, otherwise random percentage.
    // abort_after >= 0 returns once that many words have transferred on dut0.
    task automatic apply_stimulus(input int wc, input int valid_pct,
                                  input bit start_mid, input int abort_after);
        int  idx;
        bit  will_xfer;
        bit  finished;
        @(posedge clk);
        #1;
        lb0 = wa0.size();
        lb1 = wa1.size();
        @(negedge clk);
        idx        = 0;
        start      = 1'b1;
        word_count = wc[7:0];
        s_data     = (words.size() > 0) ? words[0] : 32'd0;
        s_valid    = (valid_pct != 0);
        will_xfer  = s_valid && s_ready_o[0];
        finished   = 1'b0;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            @(negedge clk);
            if (will_xfer) idx++;
            start = (start_mid && cyc == 3);
            word_count = start ? 8'd1 : wc[7:0];
            if (!busy_o[0] || (abort_after >= 0 && idx == abort_after)) begin
                finished = 1'b1;
                break;
            end
            if (idx < words.size()) begin
                s_data = words[idx];
                if (valid_pct >= 100)     s_valid = 1'b1;
                else if (valid_pct < 0)   s_valid = (cyc % 2 == 1);
                else                      s_valid = ($urandom_range(0, 99) < valid_pct);
            end else begin
                s_valid = 1'b0;
            end
            will_xfer = s_valid && s_ready_o[0];
        end
        start      = 1'b0;
        s_valid    = 1'b0;
        word_count = 8'd0;
        check_output("load_completed_in_budget", 0, 64'(finished), 64'd1);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wc;
        rstn       = 1'b0;
        start      = 1'b0;
        word_count = 8'd0;
        s_data     = 32'd0;
        s_valid    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_core_stall",   0, 64'(core_stall_o[0]),   64'd1);
        check_output("rst_busy",         0, 64'(busy_o[0]),         64'd0);
        check_output("rst_done",         0, 64'(done_o[0]),         64'd0);
        check_output("rst_words_loaded", 0, 64'(words_loaded_o[0]), 64'd0);
        @(negedge clk);
        rstn   = 1'b1;
        cmp_en = 1'b1;

        // basic load; dut1 starts at 992 so its third word hits the limit
        words = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};
        apply_stimulus(4, 100, 1'b0, -1);
        settle();
        check_output("basic_done",       0, 64'(done_o[0]),         64'd1);
        check_output("basic_stall",      0, 64'(core_stall_o[0]),   64'd0);
        check_output("basic_loaded",     0, 64'(words_loaded_o[0]), 64'd4);
        check_output("basic_nwrites",    0, 64'(wa0.size() - lb0),  64'd4);
        for (int k = 0; k < 4 && lb0 + k < wa0.size(); k++) begin
            check_output("basic_waddr", 0, wa0[lb0 + k], 64'(4 * k));
            check_output("basic_wdata", 0, 64'(wd0[lb0 + k]), 64'(words[k]));
        end
        check_output("limit_err",     1, 64'(load_err_o[1]),     64'd1);
        check_output("limit_loaded",  1, 64'(words_loaded_o[1]), 64'd2);
        check_output("limit_stall",   1, 64'(core_stall_o[1]),   64'd1);
        check_output("limit_nwrites", 1, 64'(wa1.size() - lb1),  64'd2);
        if (wa1.size() - lb1 >= 2) begin
            check_output("limit_waddr0", 1, wa1[lb1],     64'd992);
            check_output("limit_waddr1", 1, wa1[lb1 + 1], 64'd996);
        end

        // back-pressure with toggling valid; also restarts dut1 out of ERR
        words = '{32'hCAFE0001, 32'hCAFE0002};
        apply_stimulus(2, -1, 1'b0, -1);
        settle();
        check_output("bp_nwrites",   0, 64'(wa0.size() - lb0), 64'd2);
        if (wa0.size() - lb0 >= 2) begin
            check_output("bp_waddr1", 0, wa0[lb0 + 1], 64'd4);
            check_output("bp_wdata1", 0, 64'(wd0[lb0 + 1]), 64'hCAFE0002);
        end
        check_output("err_restart_done", 1, 64'(done_o[1]),     64'd1);
        check_output("err_restart_err",  1, 64'(load_err_o[1]), 64'd0);

        // zero-length image
        words = {};
        apply_stimulus(0, 100, 1'b0, -1);
        settle();
        check_output("zero_done",    0, 64'(done_o[0]),         64'd1);
        check_output("zero_loaded",  0, 64'(words_loaded_o[0]), 64'd0);
        check_output("zero_nwrites", 0, 64'(wa0.size() - lb0),  64'd0);

        // start pulsed mid-load must be ignored by dut0
        words = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        apply_stimulus(5, 100, 1'b1, -1);
        settle();
        check_output("ignore_start_loaded", 0, 64'(words_loaded_o[0]), 64'd5);
        check_output("ignore_start_done",   0, 64'(done_o[0]),         64'd1);

        // asynchronous reset after 2 of 8 words
        words = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7};
        apply_stimulus(8, 100, 1'b0, 2);
        #2;
        rstn = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_output("async_rst_stall",  i, 64'(core_stall_o[i]),   64'd1);
            check_output("async_rst_busy",   i, 64'(busy_o[i]),         64'd0);
            check_output("async_rst_ready",  i, 64'(s_ready_o[i]),      64'd0);
            check_output("async_rst_we",     i, 64'(mem_we_o[i]),       64'd0);
            check_output("async_rst_loaded", i, 64'(words_loaded_o[i]), 64'd0);
            check_output("async_rst_addr",   i, mem_addr_o[i],          64'd0);
        end
        @(negedge clk);
        rstn = 1'b1;
        words = '{32'hB0, 32'hB1, 32'hB2};
        apply_stimulus(3, 100, 1'b0, -1);
        settle();
        check_output("reload_nwrites", 0, 64'(wa0.size() - lb0), 64'd3);
        if (wa0.size() > lb0) check_output("reload_base", 0, wa0[lb0], 64'd0);

        // randomized images and valid patterns
        for (int t = 0; t < 8; t++) begin
            wc = $urandom_range(0, 20);
            words = {};
            for (int k = 0; k < wc; k++) words.push_back($urandom());
            apply_stimulus(wc, 60, ($urandom_range(0, 1) == 1), -1);
            settle();
            check_output("rand_loaded", 0, 64'(words_loaded_o[0]), 64'(wc));
            check_output("rand_done",   0, 64'(done_o[0]),         64'd1);
        end

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
